// File: rtl/neuron_array_if.sv
// Streaming interface of the neuron array.
// Input side: in_valid/in_ready handshake carrying the current for the next neuron.
// Output side: out_valid/out_ready handshake carrying index, updated v/w, spike flag
// and the end-of-timestep marker step_done.
// master: upstream scheduler + downstream router view; slave: the neuron array.
interface neuron_array_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned IDX_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_current;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [W-1:0]     out_v;
  logic [W-1:0]     out_w;
  logic             out_spike;
  logic             step_done;

  modport master (
    output in_valid, in_current, out_ready,
    input  in_ready, out_valid, out_idx, out_v, out_w, out_spike, step_done
  );

  modport slave (
    input  in_valid, in_current, out_ready,
    output in_ready, out_valid, out_idx, out_v, out_w, out_spike, step_done
  );
endinterface

// File: rtl/neuron_array_core.sv
// Time-multiplexed array of N_NEURONS two-variable fixed-point neurons (v, w).
// Each accepted input beat advances the neuron at the internal index by one Euler step
// and presents the narrowed result plus a spike flag on the output register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (same state as init, output fields cleared)
//   init  - synchronous re-initialise of all neuron states; blocks input that cycle
//   bus   - neuron_array_if slave: input current stream and result stream
module neuron_array_core #(
  parameter int unsigned INT_WIDTH  = 3,
  parameter int unsigned FRC_WIDTH  = 12,
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned TAU_SHIFT  = 1,
  parameter int unsigned TIME_SHIFT = 7,
  parameter int          A_COEF     = 2867,
  parameter int          V_TH       = 4096,
  parameter int          V_INIT     = 'hECE1,
  parameter int          W_INIT     = 'hF600,
  parameter int unsigned SATURATE   = 1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           init,
  neuron_array_if.slave bus
);

  localparam int unsigned W      = 1 + INT_WIDTH + FRC_WIDTH;
  localparam int unsigned IDX_W  = $clog2(N_NEURONS);
  localparam int unsigned WW     = W + 4;
  localparam int unsigned WP     = W + 1;
  localparam int unsigned TShift = TAU_SHIFT + TIME_SHIFT;
  // Mantissa (FRC+1 bits) shifted left by at most 2^INT_WIDTH, plus headroom.
  localparam int unsigned PW     = FRC_WIDTH + 2 + (2 ** INT_WIDTH);

  localparam logic signed [W-1:0]  VInit  = W'(V_INIT);
  localparam logic signed [W-1:0]  WInit  = W'(W_INIT);
  localparam logic signed [W-1:0]  VTh    = W'(V_TH);
  localparam logic signed [WW-1:0] ACoefX = WW'(A_COEF);
  localparam logic signed [WW-1:0] RoundV = WW'(2 ** (TIME_SHIFT - 1));
  localparam logic signed [WW-1:0] RoundW = WW'(2 ** (TShift - 1));
  localparam logic signed [WW-1:0] SatMax = WW'((2 ** (W - 1)) - 1);
  localparam logic signed [WW-1:0] SatMin = -SatMax - WW'(1);
  localparam logic [PW-1:0]        PosMax = PW'((2 ** (W - 1)) - 1);
  localparam logic [IDX_W-1:0]     LastIdx = IDX_W'(N_NEURONS - 1);

  // 2^x for signed Q(INT.FRC) x: integer part shifts the mantissa 1.f, where 2^f is
  // approximated linearly as 1+f. Result is non-negative and clamped to the W range.
  function automatic logic [W-1:0] pow2(input logic signed [WP-1:0] x);
    logic signed [WP-1:0] k;
    logic [PW-1:0]        mant;
    logic [PW-1:0]        shifted;
    k    = x >>> FRC_WIDTH;
    mant = PW'({1'b1, x[FRC_WIDTH-1:0]});
    if (!k[WP-1]) shifted = mant << k;
    else          shifted = mant >> (-k);
    if (shifted > PosMax) pow2 = PosMax[W-1:0];
    else                  pow2 = shifted[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] narrow(input logic signed [WW-1:0] x);
    if (SATURATE != 0 && x > SatMax)      narrow = SatMax[W-1:0];
    else if (SATURATE != 0 && x < SatMin) narrow = SatMin[W-1:0];
    else                                  narrow = x[W-1:0];
  endfunction

  logic signed [W-1:0]  v_mem_q [N_NEURONS];
  logic signed [W-1:0]  w_mem_q [N_NEURONS];
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 out_valid_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic signed [W-1:0]  out_v_q, out_w_q;
  logic                 out_spike_q;
  logic                 step_done_q;

  logic                 in_ready;
  logic                 accept;
  logic signed [W-1:0]  v_cur, w_cur, i_cur;
  logic [W-1:0]         p, n;
  logic signed [WW-1:0] v_x, w_x, i_x, p_x, n_x, diff, g, dv, z3, v_wide, w_wide;
  logic signed [W-1:0]  v_nxt, w_nxt;
  logic                 spike;

  assign in_ready = (!out_valid_q || bus.out_ready) && !init;
  assign accept   = bus.in_valid && in_ready;
  assign idx_d    = (idx_q == LastIdx) ? '0 : idx_q + IDX_W'(1);

  // Euler update; all sums in WW bits so nothing wraps before narrowing.
  always_comb begin
    v_cur  = v_mem_q[idx_q];
    w_cur  = w_mem_q[idx_q];
    i_cur  = bus.in_current;
    p      = pow2(WP'(v_cur));
    n      = pow2(-WP'(v_cur));
    v_x    = WW'(v_cur);
    w_x    = WW'(w_cur);
    i_x    = WW'(i_cur);
    p_x    = WW'(p);
    n_x    = WW'(n);
    diff   = n_x - p_x;
    g      = (diff <<< 1) + diff;
    dv     = (v_x <<< 2) + v_x + g - w_x + i_x;
    v_wide = v_x + ((dv + RoundV) >>> TIME_SHIFT);
    z3     = v_x + ACoefX - (w_x >>> 1);
    w_wide = w_x + ((z3 + RoundW) >>> TShift);
    v_nxt  = narrow(v_wide);
    w_nxt  = narrow(w_wide);
    spike  = (v_cur < VTh) && (v_nxt >= VTh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        v_mem_q[k] <= VInit;
        w_mem_q[k] <= WInit;
      end
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      step_done_q <= 1'b0;
      out_idx_q   <= '0;
      out_v_q     <= '0;
      out_w_q     <= '0;
      out_spike_q <= 1'b0;
    end else if (init) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        v_mem_q[k] <= VInit;
        w_mem_q[k] <= WInit;
      end
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      step_done_q <= 1'b0;
    end else if (accept) begin
      v_mem_q[idx_q] <= v_nxt;
      w_mem_q[idx_q] <= w_nxt;
      idx_q          <= idx_d;
      out_valid_q    <= 1'b1;
      out_idx_q      <= idx_q;
      out_v_q        <= v_nxt;
      out_w_q        <= w_nxt;
      out_spike_q    <= spike;
      step_done_q    <= (idx_q == LastIdx);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      step_done_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_v     = out_v_q;
  assign bus.out_w     = out_w_q;
  assign bus.out_spike = out_spike_q;
  assign bus.step_done = step_done_q;

endmodule
